muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ADDRESS_PORT_WIDTH, default 5, destination register address width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port Operand1  input  REG_WIDTH  rs1 value, from register file ReadData1.
REQ-008 SHALL have port Operand2  input  REG_WIDTH  rs2 value, from register file ReadData2.
REQ-009 SHALL have port RdIn  input  ADDRESS_PORT_WIDTH  destination register.
REQ-010 SHALL have port Busy  output  1  high while in BUSY.
REQ-011 SHALL have port Done  output  1  one-cycle result-valid pulse; drives register file RegWrite.
REQ-012 SHALL have port Result  output  REG_WIDTH  drives register file WriteData.
REQ-013 SHALL have port RdOut  output  ADDRESS_PORT_WIDTH  drives register file WriteAddress.
REQ-014 SHALL have port Illegal  output  1  one-cycle pulse with Done for an unsupported op.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE with Start=1 at edge N SHALL capture Operand1, Operand2, Funct3 and RdIn, then enter BUSY.
REQ-017 BUSY SHALL run exactly 32 iterations (one bit per cycle), then enter DONE.
REQ-018 Multiply SHALL be iterative shift-add on 33-bit sign/zero-extended operands per Funct3.
REQ-019 MUL SHALL return the low 32 bits of the 64-bit product; MULH, MULHSU and MULHU SHALL return the high 32 bits.
REQ-020 Divide SHALL be iterative restoring division on operand magnitudes, with sign fix-up in DONE.
REQ-021 DIV and REM SHALL be signed; DIVU and REMU SHALL be unsigned; quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder equal to Operand1.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0.
REQ-024 Latency SHALL be fixed for every op and special case: Done=1 in the cycle after edge N+33 (33 clocks after the Start edge).
REQ-025 DONE SHALL last exactly one cycle with Done=1, Result valid and RdOut equal to the captured RdIn, then return to IDLE.
REQ-026 Start in BUSY or DONE SHALL be ignored; the captured operands SHALL NOT change.
REQ-027 Start SHALL be accepted in the first IDLE cycle after DONE (back-to-back issue).
REQ-028 Result, RdOut and Illegal SHALL be held at 0 whenever Done=0.
REQ-029 RdIn=0 SHALL still compute and pulse Done; discarding the write SHALL be left to the register file.
REQ-030 Busy SHALL be 1 exactly in BUSY; Busy and Done SHALL never be 1 together.

Reset
REQ-031 Reset=1 at any edge SHALL force IDLE with Busy=0, Done=0, Illegal=0, Result=0, RdOut=0 and all internal registers 0.
REQ-032 Reset during BUSY or DONE SHALL abort the operation with no Done pulse, either then or later.
REQ-033 Start SHALL be ignored while Reset=1.

Configuration
REQ-034 Macro MULDIV_DIV_EN SHALL control divider inclusion.
REQ-035 With MULDIV_DIV_EN defined, the unit SHALL support all eight ops and Illegal SHALL never assert.
REQ-036 Without MULDIV_DIV_EN, the divider datapath SHALL be absent.
REQ-037 Without MULDIV_DIV_EN, Funct3[2]=1 ops SHALL keep the same 33-cycle latency, return Result=0 and pulse Illegal=1 with Done.
REQ-038 Multiply behaviour SHALL be identical with and without MULDIV_DIV_EN.

Verification
REQ-039 MUL 0x00000007 x 0xFFFFFFFD, RdIn=5 -> Done 33 cycles later, Result=0xFFFFFFEB, RdOut=5.
REQ-040 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> Result=0xFFFFFFFE; MULH of the same operands -> Result=0x00000000.
REQ-041 DIV 0xFFFFFFF9 / 2 -> Result=0xFFFFFFFD; REM of the same operands -> Result=0xFFFFFFFF; DIVU 100/0 -> Result=0xFFFFFFFF; REMU 100/0 -> Result=100.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> Result=0x80000000; REM of the same operands -> Result=0.
REQ-043 Start held high through BUSY with changing operands -> exactly one Done per accepted Start, with the result of the captured operands.
REQ-044 Reset asserted 10 cycles into BUSY -> Busy=0 next cycle and no Done within 40 cycles; then without MULDIV_DIV_EN, DIV 10/2 -> Done with Illegal=1 and Result=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Each accepted request takes a fixed 33 clocks from the Start edge to Done:
// one setup cycle followed by 32 one-bit iterations.
// Optional feature macro: MULDIV_DIV_EN. When defined, the restoring divider
// is built and all eight ops are supported. When undefined, divide ops keep
// the same latency, return 0 and raise Illegal alongside Done.
module muldiv_unit #(
    parameter int REG_WIDTH          = 32,
    parameter int ADDRESS_PORT_WIDTH = 5
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [2:0]                    Funct3,
    input  logic [REG_WIDTH-1:0]          Operand1,
    input  logic [REG_WIDTH-1:0]          Operand2,
    input  logic [ADDRESS_PORT_WIDTH-1:0] RdIn,
    output logic                          Busy,
    output logic                          Done,
    output logic [REG_WIDTH-1:0]          Result,
    output logic [ADDRESS_PORT_WIDTH-1:0] RdOut,
    output logic                          Illegal
);

    localparam int W     = REG_WIDTH;
    localparam int CNT_W = $clog2(REG_WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(REG_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT                         state;
    stateT                         nextState;
    logic [W-1:0]                  op1Reg;
    logic [W-1:0]                  op2Reg;
    logic [2:0]                    funct3Reg;
    logic [ADDRESS_PORT_WIDTH-1:0] rdReg;
    logic [CNT_W-1:0]              stepCount;

    logic [2*W-1:0] mulAcc;
    logic [2*W-1:0] mulCand;
    logic [2*W-1:0] mulAddend;
    logic [W-1:0]   mulPlier;
    logic [W-1:0]   mulResult;
    logic           op1Signed;
    logic           op2Signed;

    // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned,
    // MULHU unsigned x unsigned.
    assign op1Signed = (funct3Reg[1:0] != 2'b11);
    assign op2Signed = ~funct3Reg[1];
    assign mulResult = (funct3Reg[1:0] == 2'b00) ? mulAcc[W-1:0] : mulAcc[2*W-1:W];

    // Partial product for this iteration; a signed multiplier's top bit carries negative weight
    always_comb begin
        mulAddend = '0;
        if (mulPlier[0]) begin
            mulAddend = (stepCount == LAST_STEP && op2Signed) ? -mulCand : mulCand;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic: Start only matters in IDLE, BUSY ends after the last iteration
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = BUSY;
            BUSY:    if (stepCount == LAST_STEP) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request capture and iteration counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            op1Reg    <= '0;
            op2Reg    <= '0;
            funct3Reg <= '0;
            rdReg     <= '0;
            stepCount <= '0;
        end else if (state == IDLE && Start) begin
            op1Reg    <= Operand1;
            op2Reg    <= Operand2;
            funct3Reg <= Funct3;
            rdReg     <= RdIn;
            stepCount <= '0;
        end else if (state == BUSY) begin
            stepCount <= stepCount + 1'b1;
        end
    end

    // Shift-add multiplier: setup on step 0, then one multiplier bit per cycle
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mulAcc   <= '0;
            mulCand  <= '0;
            mulPlier <= '0;
        end else if (state == BUSY) begin
            if (stepCount == '0) begin
                mulAcc   <= '0;
                mulCand  <= op1Signed ? {{W{op1Reg[W-1]}}, op1Reg} : {{W{1'b0}}, op1Reg};
                mulPlier <= op2Reg;
            end else begin
                mulAcc   <= mulAcc + mulAddend;
                mulCand  <= mulCand << 1;
                mulPlier <= mulPlier >> 1;
            end
        end
    end

`ifdef MULDIV_DIV_EN
    logic         divSigned;
    logic         dividendNeg;
    logic         quotientNeg;
    logic [W-1:0] dividendMag;
    logic [W-1:0] divisorMag;
    logic [W-1:0] divRem;
    logic [W-1:0] divQuo;
    logic [W-1:0] divSor;
    logic [W-1:0] quotientFixed;
    logic [W-1:0] remainderFixed;
    logic [W-1:0] divResult;
    logic [W:0]   divShifted;
    logic [W:0]   divDiff;

    assign divSigned      = ~funct3Reg[0];
    assign dividendNeg    = divSigned & op1Reg[W-1];
    assign quotientNeg    = divSigned & (op1Reg[W-1] ^ op2Reg[W-1]);
    assign dividendMag    = dividendNeg ? -op1Reg : op1Reg;
    assign divisorMag     = (divSigned & op2Reg[W-1]) ? -op2Reg : op2Reg;
    assign divShifted     = {divRem, divQuo[W-1]};
    assign divDiff        = divShifted - {1'b0, divSor};
    assign quotientFixed  = quotientNeg ? -divQuo : divQuo;
    assign remainderFixed = dividendNeg ? -divRem : divRem;

    // Sign fix-up and divide-by-zero override; overflow falls out of the magnitude path
    always_comb begin
        if (op2Reg == '0) divResult = funct3Reg[1] ? op1Reg : '1;
        else              divResult = funct3Reg[1] ? remainderFixed : quotientFixed;
    end

    // Restoring divider on magnitudes: setup on step 0, then one quotient bit per cycle
    always_ff @(posedge CLK) begin
        if (Reset) begin
            divRem <= '0;
            divQuo <= '0;
            divSor <= '0;
        end else if (state == BUSY) begin
            if (stepCount == '0) begin
                divRem <= '0;
                divQuo <= dividendMag;
                divSor <= divisorMag;
            end else begin
                divRem <= divDiff[W] ? divShifted[W-1:0] : divDiff[W-1:0];
                divQuo <= {divQuo[W-2:0], ~divDiff[W]};
            end
        end
    end
`endif

    // Outputs: status from state, result fields only visible during DONE
    always_comb begin
        Busy    = (state == BUSY);
        Done    = (state == DONE);
        Result  = '0;
        RdOut   = '0;
        Illegal = 1'b0;
        if (state == DONE) begin
            RdOut = rdReg;
`ifdef MULDIV_DIV_EN
            Result = funct3Reg[2] ? divResult : mulResult;
`else
            if (funct3Reg[2]) Illegal = 1'b1;
            else              Result  = mulResult;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Directed vector table, random ops against an arithmetic reference model,
// and hand-written sequences for held Start, back-to-back issue and reset abort.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [4:0]  RdIn;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  RdOut;
    logic        Illegal;

    int checksTotal  = 0;
    int checksPassed = 0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ENABLED = 1'b1;
`else
    localparam bit DIV_ENABLED = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expResult;
    } vecT;

    vecT vectors[$];

    muldiv_unit #(.REG_WIDTH(32), .ADDRESS_PORT_WIDTH(5)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .Funct3   (Funct3),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .RdIn     (RdIn),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .RdOut    (RdOut),
        .Illegal  (Illegal)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Reference model straight from the arithmetic rules of each op
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] prod;
        int          ia, ib;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = longint'({32'h0, a});
        ub   = longint'({32'h0, b});
        ia   = $signed(a);
        ib   = $signed(b);
        prod = '0;
        if (f3[2] && !DIV_ENABLED) return 32'h0;
        case (f3)
            3'd0: begin prod = 64'(sa * sb); return prod[31:0]; end
            3'd1: begin prod = 64'(sa * sb); return prod[63:32]; end
            3'd2: begin prod = 64'(sa * ub); return prod[63:32]; end
            3'd3: begin prod = 64'(ua * ub); return prod[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic addVec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expResult);
        vecT v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.expResult = expResult;
        vectors.push_back(v);
    endtask

    // Drive one request for exactly one clock edge, which becomes the Start edge
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        Funct3   = f3;
        Operand1 = a;
        Operand2 = b;
        RdIn     = rd;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done, then check latency, payload, idle outputs and pulse width
    task automatic checkOutput(input string name, input logic [31:0] expResult, input logic [4:0] expRd, input logic expIllegal);
        int cycles;
        bit seen;
        bit protocolOk;
        cycles     = 0;
        seen       = 1'b0;
        protocolOk = 1'b1;
        while (!seen && cycles < 40) begin
            @(posedge CLK);
            #1;
            cycles++;
            if (Busy && Done) protocolOk = 1'b0;
            if (Done) seen = 1'b1;
            else if (!Busy || Result != 0 || RdOut != 0 || Illegal) protocolOk = 1'b0;
        end
        check({name, " latency"}, 32'(cycles), 32'd33);
        check({name, " result"}, Result, expResult);
        check({name, " rdOut"}, 32'(RdOut), 32'(expRd));
        check({name, " illegal"}, 32'(Illegal), 32'(expIllegal));
        check({name, " busy/quiet outputs"}, 32'(protocolOk), 32'd1);
        @(posedge CLK);
        #1;
        check({name, " done pulse width"}, 32'({Done, Busy, |Result}), 32'd0);
    endtask

    task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expResult, input logic expIllegal);
        applyStimulus(f3, a, b, rd);
        checkOutput(name, expResult, rd, expIllegal);
    endtask

    initial begin
        int firstAt, secondAt, doneCount, doneSeen, busySeen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        bit          divOp;

        Reset = 1'b1; Start = 1'b0; Funct3 = '0; Operand1 = '0; Operand2 = '0; RdIn = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset result", Result, 32'd0);
        check("reset rdOut", 32'(RdOut), 32'd0);
        check("reset illegal", 32'(Illegal), 32'd0);
        Reset = 1'b0;

        addVec(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        addVec(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE);
        addVec(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000);
        addVec(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF);
        addVec(3'd0, 32'h80000000, 32'h80000000, 5'd4,  32'h00000000);
        addVec(3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
        addVec(3'd2, 32'h80000000, 32'h80000000, 5'd7,  32'hC0000000);
        addVec(3'd0, 32'h00000003, 32'h00000004, 5'd0,  32'h0000000C);
        addVec(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD);
        addVec(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF);
        addVec(3'd5, 32'd100,      32'd0,        5'd10, 32'hFFFFFFFF);
        addVec(3'd7, 32'd100,      32'd0,        5'd11, 32'd100);
        addVec(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000);
        addVec(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000);
        addVec(3'd4, 32'h00000007, 32'd0,        5'd14, 32'hFFFFFFFF);
        addVec(3'd6, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFF9);
        addVec(3'd5, 32'hFFFFFFFF, 32'd3,        5'd16, 32'h55555555);
        addVec(3'd7, 32'd10,       32'd3,        5'd17, 32'd1);
        addVec(3'd4, 32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD);
        addVec(3'd6, 32'd7,        32'hFFFFFFFE, 5'd31, 32'd1);

        foreach (vectors[i]) begin
            divOp = vectors[i].f3[2] && !DIV_ENABLED;
            runOp($sformatf("vec%0d f3=%0d", i, vectors[i].f3), vectors[i].f3, vectors[i].a, vectors[i].b,
                  vectors[i].rd, divOp ? 32'h0 : vectors[i].expResult, divOp);
        end

        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(7));
            ra  = pickOperand();
            rb  = pickOperand();
            rrd = 5'($urandom_range(31));
            runOp($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, rf3, ra, rb), rf3, ra, rb, rrd,
                  refModel(rf3, ra, rb), rf3[2] && !DIV_ENABLED);
        end

        // Start held high through BUSY with churning operands, then back-to-back issue
        Funct3 = 3'd0; Operand1 = 32'd6; Operand2 = 32'd7; RdIn = 5'd3; Start = 1'b1;
        @(posedge CLK);
        #1;
        firstAt = 0; secondAt = 0; doneCount = 0;
        for (int c = 1; c <= 80; c++) begin
            if (doneCount == 0) begin
                Funct3   = 3'($urandom_range(7));
                Operand1 = $urandom;
                Operand2 = $urandom;
                RdIn     = 5'($urandom_range(31));
            end
            @(posedge CLK);
            #1;
            if (Done) begin
                doneCount++;
                if (doneCount == 1) begin
                    firstAt = c;
                    check("held first result", Result, 32'd42);
                    check("held first rdOut", 32'(RdOut), 32'd3);
                    Funct3 = 3'd0; Operand1 = 32'd2; Operand2 = 32'd5; RdIn = 5'd4;
                end else begin
                    secondAt = c;
                    check("back-to-back result", Result, 32'd10);
                    check("back-to-back rdOut", 32'(RdOut), 32'd4);
                end
            end
            if (doneCount == 1 && c == firstAt + 2) Start = 1'b0;
        end
        Start = 1'b0;
        check("held first latency", 32'(firstAt), 32'd33);
        check("back-to-back spacing", 32'(secondAt - firstAt), 32'd35);
        check("held done count", 32'(doneCount), 32'd2);

        // Reset 10 cycles into BUSY, with Start asserted alongside Reset
        applyStimulus(3'd4, 32'd100, 32'd7, 5'd6);
        repeat (9) @(posedge CLK);
        #1;
        Reset = 1'b1; Start = 1'b1;
        @(posedge CLK);
        #1;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b0; Start = 1'b0;
        doneSeen = 0; busySeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (Done) doneSeen++;
            if (Busy) busySeen++;
        end
        check("abort no done", 32'(doneSeen), 32'd0);
        check("start ignored in reset", 32'(busySeen), 32'd0);

        runOp("post-abort DIV 10/2", 3'd4, 32'd10, 32'd2, 5'd9, DIV_ENABLED ? 32'd5 : 32'd0, !DIV_ENABLED);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
